immediate_arbiter: RTL and testbench

- Shares one combinational Immediate_Generator between two decode-side requesters, e.g. the main decode stage and a branch/jump pre-decoder.
- Accepts 32-bit instructions on valid/ready ports and arbitrates between them, round-robin or fixed priority.
- Classifies each instruction's opcode into the codebase's instruction-type encoding (shared defines file) and drives the generator from a registered issue stage.
- Returns the sign-extended immediate, the type and an illegal flag on a per-requester valid/ready response register.

---
 rtl/immediate_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_immediate_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_arbiter.sv
// Immediate arbiter: two decode-side requesters share one combinational
// immediate generator. Requests are arbitrated, classified by opcode, held in
// a one-entry issue stage that drives the generator, and the generator's result
// is captured into a per-requester response register.

package immediate_arbiter_pkg;

  // Instruction-type encoding shared with the immediate generator.
  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } instr_type_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Result of classifying one opcode.
  typedef struct packed {
    instr_type_e itype;
    logic        illegal;
  } class_t;

  // Contents of one response register (valid kept separately).
  typedef struct packed {
    logic [31:0] immediate;
    instr_type_e itype;
    logic        illegal;
  } result_t;

  // Map an opcode to its immediate format; unknown opcodes become an
  // illegal R-type so the generator is never asked for a real immediate.
  function automatic class_t classify(input logic [6:0] opcode);
    class_t c;
    c.itype   = R_TYPE;
    c.illegal = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: c.itype = I_TYPE;
      OP_STORE:                            c.itype = S_TYPE;
      OP_BRANCH:                           c.itype = B_TYPE;
      OP_LUI, OP_AUIPC:                    c.itype = U_TYPE;
      OP_JAL:                              c.itype = J_TYPE;
      OP_REG:                              c.itype = R_TYPE;
      default:                             c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

module immediate_arbiter
  import immediate_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  input  logic [31:0] req0_instruction,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_instruction,
  output logic        req1_ready,

  output logic        resp0_valid,
  output logic [31:0] resp0_immediate,
  output logic [2:0]  resp0_type,
  output logic        resp0_illegal,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_immediate,
  output logic [2:0]  resp1_type,
  output logic        resp1_illegal,
  input  logic        resp1_ready,

  output logic [24:0] gen_instruction,
  output logic [2:0]  gen_instruction_type,
  input  logic [31:0] gen_immediate
);

  // Arbitration state: which requester won the last accepted transfer.
  logic        last_grant;
  logic        grant0;
  logic        grant1;

  // One-entry issue stage feeding the shared generator.
  logic        issue_valid;
  logic        issue_owner;
  logic [24:0] issue_instruction;
  instr_type_e issue_type;
  logic        issue_illegal;

  logic        issue_fire;
  logic        issue_free;
  logic        accept;
  logic        accept_id;
  logic [31:0] accept_instruction;
  class_t      accept_class;

  // Response registers, indexed by requester.
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  result_t     resp_data [2];
  result_t     capture_data;

  // Grant one requester from the valids and the last-grant pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (ROUND_ROBIN && !last_grant) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b1;
      end
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // The issue entry leaves when its owner's response slot is empty or
  // draining; a new request may enter in that same cycle.
  assign resp_ready = {resp1_ready, resp0_ready};
  assign issue_fire = issue_valid &&
                      (!resp_valid[issue_owner] || resp_ready[issue_owner]);
  assign issue_free = !issue_valid || issue_fire;

  assign req0_ready = grant0 && issue_free;
  assign req1_ready = grant1 && issue_free;

  // Grants are exclusive, so a ready implies that requester's transfer.
  assign accept             = req0_ready || req1_ready;
  assign accept_id          = req1_ready;
  assign accept_instruction = req1_ready ? req1_instruction : req0_instruction;
  assign accept_class       = classify(accept_instruction[6:0]);

  // Move the round-robin pointer to the requester just accepted.
  always_ff @(posedge clk) begin
    // NOTE: clocked blocks use non-blocking assignments so every register samples values from before the edge.
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= accept_id;
    end
  end

  // Load the issue stage on accept, empty it when it fires; the payload
  // is kept while empty so the generator inputs stay at their last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid       <= 1'b0;
      issue_owner       <= 1'b0;
      issue_instruction <= '0;
      issue_type        <= R_TYPE;
      issue_illegal     <= 1'b0;
    end else if (accept) begin
      issue_valid       <= 1'b1;
      issue_owner       <= accept_id;
      issue_instruction <= accept_instruction[31:7];
      issue_type        <= accept_class.itype;
      issue_illegal     <= accept_class.illegal;
    end else if (issue_fire) begin
      issue_valid       <= 1'b0;
    end
  end

  assign gen_instruction      = issue_instruction;
  assign gen_instruction_type = issue_type;

  // R-type has no immediate; force zero instead of trusting whatever the
  // generator leaves on its output for that format.
  always_comb begin
    capture_data.immediate = (issue_type == R_TYPE) ? 32'h0 : gen_immediate;
    capture_data.itype     = issue_type;
    capture_data.illegal   = issue_illegal;
  end

  for (genvar n = 0; n < 2; n++) begin : g_resp
    localparam logic ID = 1'(n);

    logic    valid_q;
    result_t data_q;

    // Capture on the owner's fire; otherwise drop valid when consumed.
    // A capture and a consume in the same cycle keeps valid with new data.
    always_ff @(posedge clk) begin
      // NOTE: payload registers are reset as well, because the response outputs must read 0 after reset rather than stale data.
      if (reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (issue_fire && (issue_owner == ID)) begin
        valid_q <= 1'b1;
        data_q  <= capture_data;
      end else if (resp_ready[n]) begin
        valid_q <= 1'b0;
      end
    end

    assign resp_valid[n] = valid_q;
    assign resp_data[n]  = data_q;
  end

  assign resp0_valid     = resp_valid[0];
  assign resp0_immediate = resp_data[0].immediate;
  assign resp0_type      = resp_data[0].itype;
  assign resp0_illegal   = resp_data[0].illegal;

  assign resp1_valid     = resp_valid[1];
  assign resp1_immediate = resp_data[1].immediate;
  assign resp1_type      = resp_data[1].itype;
  assign resp1_illegal   = resp_data[1].illegal;

endmodule

// File: tb/tb_immediate_arbiter.sv
// Testbench for immediate_arbiter: a round-robin and a fixed-priority instance
// share stimulus; each is paired with a behavioural immediate generator.
`timescale 1ns/1ps

module tb_immediate_arbiter;
  import immediate_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_instruction = '0, req1_instruction = '0;
  logic        resp0_ready = 1'b1, resp1_ready = 1'b1;

  // Round-robin instance outputs.
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid, resp0_illegal, resp1_illegal;
  logic [31:0] resp0_immediate, resp1_immediate;
  logic [2:0]  resp0_type, resp1_type;
  logic [24:0] gen_instruction;
  logic [2:0]  gen_instruction_type;
  logic [31:0] gen_immediate;

  // Fixed-priority instance outputs.
  logic        fp_req0_ready, fp_req1_ready;
  logic        fp_resp0_valid, fp_resp1_valid, fp_resp0_illegal, fp_resp1_illegal;
  logic [31:0] fp_resp0_immediate, fp_resp1_immediate;
  logic [2:0]  fp_resp0_type, fp_resp1_type;
  logic [24:0] fp_gen_instruction;
  logic [2:0]  fp_gen_instruction_type;
  logic [31:0] fp_gen_immediate;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  itype;
    logic        illegal;
  } vec_t;

  always #5 clk = ~clk;

  // Immediate formats straight from the ISA bit layouts; R-type returns junk
  // so that the DUT's masking is exercised.
  function automatic logic [31:0] imm_of(input logic [31:0] ins, input logic [2:0] t);
    case (t)
      I_TYPE:  return {{20{ins[31]}}, ins[31:20]};
      S_TYPE:  return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      B_TYPE:  return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      U_TYPE:  return {ins[31:12], 12'h0};
      J_TYPE:  return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign gen_immediate    = imm_of({gen_instruction, 7'b0}, gen_instruction_type);
  assign fp_gen_immediate = imm_of({fp_gen_instruction, 7'b0}, fp_gen_instruction_type);

  // Expected response for an instruction word.
  function automatic vec_t expect_of(input logic [31:0] ins);
    vec_t e;
    e.instr   = ins;
    e.illegal = 1'b0;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: e.itype = I_TYPE;
      7'b0100011: e.itype = S_TYPE;
      7'b1100011: e.itype = B_TYPE;
      7'b0110111, 7'b0010111: e.itype = U_TYPE;
      7'b1101111: e.itype = J_TYPE;
      7'b0110011: e.itype = R_TYPE;
      default: begin e.itype = R_TYPE; e.illegal = 1'b1; end
    endcase
    e.imm = (e.itype == R_TYPE) ? 32'h0 : imm_of(ins, e.itype);
    return e;
  endfunction

  immediate_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_instruction(req0_instruction), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_instruction(req1_instruction), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_immediate(resp0_immediate), .resp0_type(resp0_type),
    .resp0_illegal(resp0_illegal), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_immediate(resp1_immediate), .resp1_type(resp1_type),
    .resp1_illegal(resp1_illegal), .resp1_ready(resp1_ready),
    .gen_instruction(gen_instruction), .gen_instruction_type(gen_instruction_type),
    .gen_immediate(gen_immediate)
  );

  immediate_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_instruction(req0_instruction), .req0_ready(fp_req0_ready),
    .req1_valid(req1_valid), .req1_instruction(req1_instruction), .req1_ready(fp_req1_ready),
    .resp0_valid(fp_resp0_valid), .resp0_immediate(fp_resp0_immediate), .resp0_type(fp_resp0_type),
    .resp0_illegal(fp_resp0_illegal), .resp0_ready(resp0_ready),
    .resp1_valid(fp_resp1_valid), .resp1_immediate(fp_resp1_immediate), .resp1_type(fp_resp1_type),
    .resp1_illegal(fp_resp1_illegal), .resp1_ready(resp1_ready),
    .gen_instruction(fp_gen_instruction), .gen_instruction_type(fp_gen_instruction_type),
    .gen_immediate(fp_gen_immediate)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Advance to the next falling edge; inputs are driven there.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [6:0] opcodes [10] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
                               7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) w[6:0] = opcodes[k];
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    vec_t e;
    vec_t q0 [$];
    vec_t q1 [$];
    int c0, c1;
    logic pend0, pend1;

    vecs[0] = '{32'hFFF00093, 32'hFFFFFFFF, I_TYPE, 1'b0};
    vecs[1] = '{32'h123452B7, 32'h12345000, U_TYPE, 1'b0};
    vecs[2] = '{32'h0080006F, 32'h00000008, J_TYPE, 1'b0};
    vecs[3] = '{32'hFE000EE3, 32'hFFFFFFFC, B_TYPE, 1'b0};
    vecs[4] = '{32'h0040A223, 32'h00000004, S_TYPE, 1'b0};
    vecs[5] = '{32'h003100B3, 32'h00000000, R_TYPE, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000000, R_TYPE, 1'b1};

    // Reset state.
    step(); step();
    reset = 1'b0;
    #1;
    check("reset_resp_valid", 32'({resp0_valid, resp1_valid}), 0);
    check("reset_resp0_imm", resp0_immediate, 0);
    check("reset_resp1_imm", resp1_immediate, 0);
    check("reset_types_illegal", 32'({resp0_type, resp1_type, resp0_illegal, resp1_illegal}), 0);
    check("reset_gen", 32'({gen_instruction, gen_instruction_type}), 0);

    // Single requests through each format, latency N+2.
    for (int i = 0; i < 7; i++) begin
      step();
      req0_valid = 1'b1;
      req0_instruction = vecs[i].instr;
      #1;
      check("single_accept", 32'(req0_ready), 1);
      step();
      req0_valid = 1'b0;
      #1;
      check("single_n1_not_valid", 32'(resp0_valid), 0);
      check("single_gen_instr", 32'(gen_instruction), 32'(vecs[i].instr[31:7]));
      check("single_gen_type", 32'(gen_instruction_type), 32'(vecs[i].itype));
      step();
      #1;
      check("single_n2_valid", 32'(resp0_valid), 1);
      check("single_imm", resp0_immediate, vecs[i].imm);
      check("single_type", 32'(resp0_type), 32'(vecs[i].itype));
      check("single_illegal", 32'(resp0_illegal), 32'(vecs[i].illegal));
      check("single_gen_hold", 32'(gen_instruction), 32'(vecs[i].instr[31:7]));
      check("single_gen_known", 32'($isunknown({gen_instruction, gen_instruction_type})), 0);
    end

    // Round-robin contention after reset: grants 0,1,0,1.
    do_reset();
    c0 = 0;
    c1 = 0;
    req0_instruction = 32'hFFF00093;
    req1_instruction = 32'h123452B7;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      req0_valid = (i < 4);
      req1_valid = (i < 4);
      #1;
      if (i < 4) begin
        check("rr_grant0", 32'(req0_ready), 32'(i % 2 == 0));
        check("rr_grant1", 32'(req1_ready), 32'(i % 2 == 1));
      end
      if (resp0_valid) begin
        c0++;
        check("rr_resp0_imm", resp0_immediate, 32'hFFFFFFFF);
      end
      if (resp1_valid) begin
        c1++;
        check("rr_resp1_imm", resp1_immediate, 32'h12345000);
      end
    end
    check("rr_resp0_count", 32'(c0), 2);
    check("rr_resp1_count", 32'(c1), 2);

    // Fixed priority: requester 0 always wins, requester 1 waits.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      req0_valid = (i < 3);
      req1_valid = 1'b1;
      #1;
      if (i < 3) begin
        check("fp_req0_ready", 32'(fp_req0_ready), 1);
        check("fp_req1_ready", 32'(fp_req1_ready), 0);
      end else begin
        check("fp_req1_after_drop", 32'(fp_req1_ready), 1);
      end
    end
    step();
    req1_valid = 1'b0;

    // Backpressure on response 0.
    do_reset();
    resp0_ready = 1'b0;
    req0_valid = 1'b1;
    req0_instruction = 32'hFFF00093;
    #1;
    check("bp_accept_a", 32'(req0_ready), 1);
    step();
    req0_instruction = 32'h123452B7;
    #1;
    check("bp_accept_b", 32'(req0_ready), 1);
    for (int i = 0; i < 2; i++) begin
      step();
      req0_instruction = 32'h0080006F;
      req1_valid = 1'b1;
      req1_instruction = 32'h003100B3;
      #1;
      check("bp_hold_valid", 32'(resp0_valid), 1);
      check("bp_hold_imm", resp0_immediate, 32'hFFFFFFFF);
      check("bp_stall_ready", 32'({req0_ready, req1_ready}), 0);
    end
    step();
    resp0_ready = 1'b1;
    req1_valid = 1'b0;
    #1;
    check("bp_release_accept_c", 32'(req0_ready), 1);
    step();
    req0_valid = 1'b0;
    #1;
    check("bp_b_valid", 32'(resp0_valid), 1);
    check("bp_b_imm", resp0_immediate, 32'h12345000);
    check("bp_resp1_quiet", 32'(resp1_valid), 0);
    step();
    #1;
    check("bp_c_valid", 32'(resp0_valid), 1);
    check("bp_c_imm", resp0_immediate, 32'h00000008);
    step();
    #1;
    check("bp_drained", 32'(resp0_valid), 0);

    // Reset the cycle after an accept: nothing emerges, pointer restored.
    step();
    req0_valid = 1'b1;
    req0_instruction = 32'hFFF00093;
    #1;
    check("rst_mid_accept", 32'(req0_ready), 1);
    step();
    req0_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_mid_outputs",
          32'({resp0_valid, resp1_valid, resp0_type, resp1_type, resp0_illegal, resp1_illegal}), 0);
    check("rst_mid_imm", resp0_immediate | resp1_immediate, 0);
    check("rst_mid_gen", 32'({gen_instruction, gen_instruction_type}), 0);
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      check("rst_mid_no_resp", 32'({resp0_valid, resp1_valid}), 0);
    end
    step();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rst_mid_conflict0", 32'(req0_ready), 1);
    check("rst_mid_conflict1", 32'(req1_ready), 0);
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b0;

    // Randomized traffic against the scoreboard.
    do_reset();
    pend0 = 1'b0;
    pend1 = 1'b0;
    for (int cyc = 0; cyc < 1700; cyc++) begin
      step();
      if (cyc < 1500) begin
        if (!pend0) begin
          req0_valid = ($urandom_range(0, 99) < 60);
          req0_instruction = rand_instr();
        end
        if (!pend1) begin
          req1_valid = ($urandom_range(0, 99) < 60);
          req1_instruction = rand_instr();
        end
        resp0_ready = ($urandom_range(0, 99) < 70);
        resp1_ready = ($urandom_range(0, 99) < 70);
      end else begin
        if (!pend0) req0_valid = 1'b0;
        if (!pend1) req1_valid = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
      end
      #1;
      if (req0_ready && req1_ready) check("rand_ready_exclusive", 1, 0);
      if (resp0_valid && resp0_ready) begin
        if (q0.size() == 0) check("rand_resp0_unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          check("rand_resp0_imm", resp0_immediate, e.imm);
          check("rand_resp0_type", 32'({resp0_type, resp0_illegal}), 32'({e.itype, e.illegal}));
        end
      end
      if (resp1_valid && resp1_ready) begin
        if (q1.size() == 0) check("rand_resp1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          check("rand_resp1_imm", resp1_immediate, e.imm);
          check("rand_resp1_type", 32'({resp1_type, resp1_illegal}), 32'({e.itype, e.illegal}));
        end
      end
      if (req0_valid && req0_ready) q0.push_back(expect_of(req0_instruction));
      if (req1_valid && req1_ready) q1.push_back(expect_of(req1_instruction));
      pend0 = req0_valid && !req0_ready;
      pend1 = req1_valid && !req1_ready;
    end
    check("rand_q0_drained", 32'(q0.size()), 0);
    check("rand_q1_drained", 32'(q1.size()), 0);
    check("rand_no_pending", 32'({pend0, pend1}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
